// File: rtl/line_rasterizer.sv
// Bresenham edge rasterizer: walks from (x0,y0) to (x1,y1) and emits one pixel per cycle.
// A four-state FSM latches the endpoints, sets up the error terms, draws, and pulses done.
module line_rasterizer #(
  parameter int DATA_W = 10
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              draw_line_start,
  input  logic [DATA_W-1:0] x0,
  input  logic [DATA_W-1:0] y0,
  input  logic [DATA_W-1:0] x1,
  input  logic [DATA_W-1:0] y1,
  output logic [DATA_W-1:0] DrawX,
  output logic [DATA_W-1:0] DrawY,
  output logic              DrawValid,
  output logic              draw_line_done
);

  localparam int ERR_W = DATA_W + 2;

  typedef enum logic [1:0] {IDLE, INIT, DRAW, DONE} state_t;
  state_t state, state_nxt;

  logic        [DATA_W-1:0] x0_r, y0_r, x1_r, y1_r;
  logic        [DATA_W-1:0] cur_x, cur_y;
  logic signed [ERR_W-1:0]  dx, dy, err;
  logic                     sx_neg, sy_neg;

  logic signed [ERR_W:0]    e2, dx_ext, dy_ext;
  logic signed [ERR_W-1:0]  err_nxt, add_x, add_y;
  logic                     step_x, step_y, at_end;

  function automatic logic signed [ERR_W-1:0] abs_diff(input logic [DATA_W-1:0] a,
                                                      input logic [DATA_W-1:0] b);
    logic [DATA_W-1:0] mag;
    mag = (a >= b) ? a - b : b - a;
    return signed'({2'b00, mag});
  endfunction

  function automatic logic [DATA_W-1:0] step(input logic [DATA_W-1:0] v, input logic neg);
    return neg ? v - 1'b1 : v + 1'b1;
  endfunction

  // Both axis decisions use the same e2, so a diagonal move folds dy+dx into err at once.
  always_comb begin
    e2      = {err, 1'b0};
    dx_ext  = {dx[ERR_W-1], dx};
    dy_ext  = {dy[ERR_W-1], dy};
    step_x  = (e2 >= dy_ext);
    step_y  = (e2 <= dx_ext);
    add_x   = step_x ? dy : '0;
    add_y   = step_y ? dx : '0;
    err_nxt = err + add_x + add_y;
    at_end  = (cur_x == x1_r) && (cur_y == y1_r);
  end

  always_ff @(posedge Clk) begin
    if (Reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt      = state;
    DrawValid      = 1'b0;
    draw_line_done = 1'b0;
    unique case (state)
      IDLE: if (draw_line_start) state_nxt = INIT;
      INIT: state_nxt = DRAW;
      DRAW: begin
        DrawValid = 1'b1;
        if (at_end) state_nxt = DONE;
      end
      DONE: begin
        draw_line_done = 1'b1;
        state_nxt      = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      x0_r   <= '0;
      y0_r   <= '0;
      x1_r   <= '0;
      y1_r   <= '0;
      cur_x  <= '0;
      cur_y  <= '0;
      dx     <= '0;
      dy     <= '0;
      err    <= '0;
      sx_neg <= 1'b0;
      sy_neg <= 1'b0;
    end else begin
      unique case (state)
        IDLE: if (draw_line_start) begin
          x0_r <= x0;
          y0_r <= y0;
          x1_r <= x1;
          y1_r <= y1;
        end
        INIT: begin
          dx     <= abs_diff(x1_r, x0_r);
          dy     <= -abs_diff(y1_r, y0_r);
          err    <= abs_diff(x1_r, x0_r) - abs_diff(y1_r, y0_r);
          sx_neg <= !(x0_r < x1_r);
          sy_neg <= !(y0_r < y1_r);
          cur_x  <= x0_r;
          cur_y  <= y0_r;
        end
        DRAW: if (!at_end) begin
          if (step_x) cur_x <= step(cur_x, sx_neg);
          if (step_y) cur_y <= step(cur_y, sy_neg);
          err <= err_nxt;
        end
        default: ;
      endcase
    end
  end

  // The walking position doubles as the output, so it holds outside DRAW.
  assign DrawX = cur_x;
  assign DrawY = cur_y;

endmodule

// File: doc/line_rasterizer.md
LINE_RASTERIZER -- requirements
Module: line_rasterizer

Interface
REQ-001 Clk  input  1  rising-edge clock for all state.
REQ-002 Reset  input  1  synchronous, active-high; sampled on rising Clk.
REQ-003 draw_line_start  input  1  request pulse; accepted only in IDLE.
REQ-004 x0, y0  input  10 each  start endpoint, unsigned screen coordinates.
REQ-005 x1, y1  input  10 each  end endpoint, unsigned screen coordinates.
REQ-006 DrawX, DrawY  output  10 each  current edge pixel coordinate.
REQ-007 DrawValid  output  1  high in every cycle where DrawX/DrawY is a pixel to plot.
REQ-008 draw_line_done  output  1  single-cycle completion pulse.

Function
REQ-009 The block SHALL implement a four-state FSM: IDLE, INIT, DRAW, DONE.
REQ-010 IDLE: if draw_line_start=1, the block SHALL latch x0,y0,x1,y1 into internal registers and go to INIT; otherwise it stays in IDLE.
REQ-011 Endpoint inputs SHALL be ignored after latching; changes during INIT/DRAW/DONE have no effect.
REQ-012 INIT (one cycle) SHALL compute dx=|x1-x0|, dy=-|y1-y0|, sx=+1 if x0<x1 else -1, sy=+1 if y0<y1 else -1, and err=dx+dy; it SHALL load cur_x=x0, cur_y=y0; DrawValid=0.
REQ-013 err, dx and dy SHALL be 12-bit signed; e2=2*err SHALL be 13-bit signed; no overflow is possible for 10-bit coordinates.
REQ-014 DRAW: in each cycle, DrawX=cur_x, DrawY=cur_y, and DrawValid=1.
REQ-015 DRAW: if cur_x==x1 and cur_y==y1, the next state SHALL be DONE and no coordinate update occurs.
REQ-016 DRAW otherwise: e2=2*err; if e2>=dy then err+=dy and cur_x+=sx; if e2<=dx then err+=dx and cur_y+=sy.
REQ-017 When both conditions in REQ-016 hold in the same cycle, both updates SHALL apply in that cycle, and err SHALL accumulate dy+dx.
REQ-018 The block SHALL support all eight octants plus horizontal, vertical and zero-length lines.
REQ-019 Pixel count SHALL be N=max(|x1-x0|,|y1-y0|)+1, emitted on N consecutive cycles with no gaps or duplicates.
REQ-020 Latency: with start sampled in cycle t, the first pixel (x0,y0) SHALL appear in cycle t+2, the last pixel in cycle t+1+N, and draw_line_done=1 in cycle t+2+N only.
REQ-021 DONE SHALL assert draw_line_done for exactly one cycle and go unconditionally to IDLE.
REQ-022 A start presented in the cycle immediately after the done pulse SHALL be accepted, so back-to-back edge requests work without an idle gap.
REQ-023 draw_line_start asserted in INIT, DRAW or DONE SHALL be ignored and SHALL NOT be queued.
REQ-024 Outside DRAW, DrawValid=0 and DrawX/DrawY SHALL hold their last driven value.
REQ-025 Coordinates SHALL never leave the bounding box of the two endpoints.

Reset
REQ-026 While Reset=1, the FSM SHALL be in IDLE, and DrawX=0, DrawY=0, DrawValid=0, draw_line_done=0; all internal registers SHALL be cleared.
REQ-027 Reset asserted mid-line SHALL abort the line on the next edge with no done pulse; a start in the first cycle after Reset deasserts SHALL be accepted.

Verification
REQ-028 Horizontal line (0,0)->(3,0): the bench SHALL check pixels (0,0),(1,0),(2,0),(3,0) on consecutive cycles, then done in the following cycle.
REQ-029 Steep negative line (5,5)->(4,1): the bench SHALL check the exact pixel sequence (5,5),(5,4),(4,3),(4,2),(4,1).
REQ-030 Diagonal line (0,0)->(2,2): the bench SHALL check pixels (0,0),(1,1),(2,2), confirming both axes step in the same cycle.
REQ-031 Point (7,9)->(7,9): the bench SHALL check a single pixel at t+2 and done at t+3.
REQ-032 Back-to-back requests, where the second start arrives the cycle after done: the bench SHALL check that both lines are drawn fully, and that a start pulse asserted mid-DRAW is ignored.
REQ-033 Reset asserted during pixel 3 of (0,0)->(9,0): the bench SHALL check that outputs are zero in the next cycle, no done pulse occurs, and a new line is accepted afterward.
